sram_store_unit: RTL
====================

Name: sram_store_unit

Overview:
- Write-side counterpart of the MEM-stage load path.
- Accepts store requests (SB/SW) from the EX/MEM boundary into a small in-order store buffer.
- Formats byte enables and lane data, and drives the external SRAM write cycle through a SETUP/WRITE/HOLD state machine with a programmable write-strobe width.
- Exposes buffer-drained status so the pipeline can hold loads until pending stores have retired.

Parameters:
- DEPTH, 2, store-buffer entries (power of two, >=2).
- WAIT_CYCLES, 1, cycles SRAM_WE_N is held low per write (>=1).
- ADDR_W, 20, width of the SRAM word address.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset (`RST_EN` = 1).
- REQ_VALID  input  1  store request present this cycle.
- REQ_READY  output  1  buffer can accept; a transfer occurs when REQ_VALID && REQ_READY.
- REQ_OP  input  `ALU_OP_BUS`  `EXE_SB_OP` or `EXE_SW_OP`; any other value is consumed and discarded.
- REQ_ADDR  input  32  byte address.
- REQ_DATA  input  `REG_DATA_BUS`  store data (SB uses [7:0]).
- ADDR_ERR  output  1  one-cycle pulse: misaligned SW was rejected.
- DRAINED  output  1  buffer empty and FSM in IDLE.
- SRAM_ADDR  output  ADDR_W  word address = REQ_ADDR[ADDR_W+1:2].
- SRAM_WDATA  output  `SRAM_DATA_BUS`  write data.
- SRAM_BE  output  `SRAM_BSEL_BUS`  active-low byte enables.
- SRAM_CE_N  output  1  chip enable, active low.
- SRAM_WE_N  output  1  write enable, active low.

Behaviour:
- Reset (async, immediate, may interrupt a write mid-cycle):
  - Buffer cleared; FSM goes to IDLE; the aborted entry is lost.
  - SRAM_CE_N=1, SRAM_WE_N=1, SRAM_BE=4'b1111, SRAM_ADDR=0, SRAM_WDATA=0, ADDR_ERR=0.
  - REQ_READY=0 while RST is high; DRAINED=1.
- Formatting at enqueue (stored pre-formatted in the entry):
  - SB: BE = 1110, 1101, 1011, 0111 for addr[1:0] = 0, 1, 2, 3. Data byte replicated to all four lanes.
  - SW with addr[1:0]=0: BE=0000, data unchanged.
  - SW with addr[1:0]!=0: request consumed, not enqueued; ADDR_ERR pulses high the following cycle.
  - Other REQ_OP: consumed silently; no error, no entry.
- Buffer:
  - FIFO with DEPTH entries; REQ_READY = !full, driven combinationally from registered count.
  - When full, a request is not accepted even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
- All SRAM_* outputs are registered.
- FSM:
  - IDLE: CE_N=1, WE_N=1, BE=1111. If buffer non-empty -> SETUP.
  - SETUP (1 cycle): head entry driven on ADDR/WDATA/BE; CE_N=0, WE_N=1 -> WRITE.
  - WRITE: WE_N=0 for exactly WAIT_CYCLES cycles (counter loaded on entry); ADDR/WDATA/BE stable -> HOLD.
  - HOLD (1 cycle): WE_N=1, CE_N=0, ADDR/WDATA/BE still stable; head popped at end of cycle. Then -> SETUP if another entry remains after the pop, else -> IDLE.
  - Latency: a single store into an empty unit reaches SETUP 1 cycle after the accept edge and completes after 2+WAIT_CYCLES cycles of SRAM activity.
  - Back-to-back throughput: one store per 2+WAIT_CYCLES cycles.
- DRAINED = (count==0) && (state==IDLE), combinational from registers.
- Address/data outputs never change while WE_N=0.

Test Plan:
- Reset released, SB addr=0x0000_0006 data=0x1234_56A5 -> SETUP: BE=1011, WDATA=0xA5A5_A5A5, ADDR=0x1; WE_N low 1 cycle; DRAINED returns to 1 after HOLD.
- SW addr=0x0000_0010 data=0xDEAD_BEEF, WAIT_CYCLES=3 -> BE=0000, ADDR=0x4, WE_N low exactly 3 cycles, ADDR/WDATA stable from SETUP through HOLD.
- SW addr=0x0000_0012 -> no SRAM activity, ADDR_ERR high for exactly 1 cycle, REQ_READY stays 1, DRAINED stays 1.
- Three valid stores issued on consecutive cycles with DEPTH=2 -> REQ_READY drops after the second is accepted, third accepted only after the first pop. All three are written in order with HOLD->SETUP back-to-back and no IDLE gap.
- RST asserted while WE_N=0 -> WE_N and CE_N go high immediately (same cycle, asynchronous), BE=1111, buffer empty, DRAINED=1. After release, a new SB is written normally.
- REQ_OP = `EXE_LW_OP` with REQ_VALID=1 -> consumed, no entry, no ADDR_ERR, no SRAM cycle.

Source files
------------

// File: rtl/sram_store_unit.sv
// sram_store_unit: in-order store buffer feeding an asynchronous SRAM write
// port. Stores are formatted (byte enables, lane replication) when they are
// enqueued, then retired one at a time through a SETUP/WRITE/HOLD cycle with a
// programmable write-strobe width.

`ifndef RST_EN
`define RST_EN 1'b1
`endif
`ifndef ALU_OP_BUS
`define ALU_OP_BUS 7:0
`endif
`ifndef REG_DATA_BUS
`define REG_DATA_BUS 31:0
`endif
`ifndef SRAM_DATA_BUS
`define SRAM_DATA_BUS 31:0
`endif
`ifndef SRAM_BSEL_BUS
`define SRAM_BSEL_BUS 3:0
`endif
`ifndef EXE_SB_OP
`define EXE_SB_OP 8'b11101000
`endif
`ifndef EXE_SW_OP
`define EXE_SW_OP 8'b11101011
`endif
`ifndef EXE_LW_OP
`define EXE_LW_OP 8'b11100011
`endif

module sram_store_unit #(
   parameter int DEPTH       = 2,
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 20
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   REQ_VALID,
   output logic                   REQ_READY,
   input  logic [`ALU_OP_BUS]     REQ_OP,
   input  logic [31:0]            REQ_ADDR,
   input  logic [`REG_DATA_BUS]   REQ_DATA,
   output logic                   ADDR_ERR,
   output logic                   DRAINED,
   output logic [ADDR_W-1:0]      SRAM_ADDR,
   output logic [`SRAM_DATA_BUS]  SRAM_WDATA,
   output logic [`SRAM_BSEL_BUS]  SRAM_BE,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_WE_N
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WRITE = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   // Active-low byte enable for a single byte store in the given lane.
   function automatic logic [3:0] sb_byte_en(input logic [1:0] lane);
      logic [3:0] be;
      case (lane)
         2'd0:    be = 4'b1110;
         2'd1:    be = 4'b1101;
         2'd2:    be = 4'b1011;
         2'd3:    be = 4'b0111;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Buffer storage (pre-formatted entries) and control state.
   logic [ADDR_W-1:0]  addr_mem_r [DEPTH];
   logic [31:0]        data_mem_r [DEPTH];
   logic [3:0]         be_mem_r   [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   state_t             state_r;
   logic [WCNT_W-1:0]  wcnt_r;

   logic [ADDR_W-1:0]  sram_addr_r;
   logic [31:0]        sram_wdata_r;
   logic [3:0]         sram_be_r;
   logic               sram_ce_n_r;
   logic               sram_we_n_r;
   logic               addr_err_r;

   logic               is_sb_s;
   logic               is_sw_s;
   logic               accept_s;
   logic               misalign_s;
   logic               push_s;
   logic               pop_s;
   logic               full_s;
   logic [ADDR_W-1:0]  fmt_addr_s;
   logic [31:0]        fmt_data_s;
   logic [3:0]         fmt_be_s;
   logic [PTR_W-1:0]   rd_next_s;

   state_t             state_nx_s;
   logic [WCNT_W-1:0]  wcnt_nx_s;
   logic [ADDR_W-1:0]  head_addr_s;
   logic [31:0]        head_data_s;
   logic [3:0]         head_be_s;
   logic [ADDR_W-1:0]  addr_nx_s;
   logic [31:0]        wdata_nx_s;
   logic [3:0]         be_nx_s;
   logic               ce_n_nx_s;
   logic               we_n_nx_s;

   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign REQ_READY = (RST != `RST_EN) && !full_s;
   assign DRAINED   = (count_r == CNT_W'(0)) && (state_r == ST_IDLE);
   assign pop_s     = (state_r == ST_HOLD);
   assign rd_next_s = rd_ptr_r + PTR_W'(1);

   assign SRAM_ADDR  = sram_addr_r;
   assign SRAM_WDATA = sram_wdata_r;
   assign SRAM_BE    = sram_be_r;
   assign SRAM_CE_N  = sram_ce_n_r;
   assign SRAM_WE_N  = sram_we_n_r;
   assign ADDR_ERR   = addr_err_r;

   // Decode the incoming request and build the formatted buffer entry.
   always_comb begin
      is_sb_s    = (REQ_OP == `EXE_SB_OP);
      is_sw_s    = (REQ_OP == `EXE_SW_OP);
      accept_s   = REQ_VALID && REQ_READY;
      misalign_s = is_sw_s && (REQ_ADDR[1:0] != 2'b00);
      push_s     = accept_s && (is_sb_s || (is_sw_s && !misalign_s));
      fmt_addr_s = REQ_ADDR[ADDR_W+1:2];
      if (is_sb_s) begin
         fmt_be_s   = sb_byte_en(REQ_ADDR[1:0]);
         fmt_data_s = {4{REQ_DATA[7:0]}};
      end else begin
         fmt_be_s   = 4'b0000;
         fmt_data_s = REQ_DATA;
      end
   end

   // Entry that the next SETUP will present: leaving HOLD the head advances,
   // and a store pushed in that same cycle into an otherwise empty buffer is
   // forwarded directly so back-to-back retirement has no idle gap.
   always_comb begin
      if (state_r == ST_HOLD) begin
         if (count_r > CNT_W'(1)) begin
            head_addr_s = addr_mem_r[rd_next_s];
            head_data_s = data_mem_r[rd_next_s];
            head_be_s   = be_mem_r[rd_next_s];
         end else begin
            head_addr_s = fmt_addr_s;
            head_data_s = fmt_data_s;
            head_be_s   = fmt_be_s;
         end
      end else begin
         head_addr_s = addr_mem_r[rd_ptr_r];
         head_data_s = data_mem_r[rd_ptr_r];
         head_be_s   = be_mem_r[rd_ptr_r];
      end
   end

   // Next-state logic for the SRAM write cycle, plus next values of the
   // registered SRAM pins (decoded from the state being entered).
   always_comb begin
      state_nx_s = state_r;
      wcnt_nx_s  = wcnt_r;
      case (state_r)
         ST_IDLE: begin
            if (count_r != CNT_W'(0)) begin
               state_nx_s = ST_SETUP;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_nx_s = ST_WRITE;
            wcnt_nx_s  = WCNT_W'(WAIT_CYCLES - 1);
         end
         ST_WRITE: begin
            if (wcnt_r == WCNT_W'(0)) begin
               state_nx_s = ST_HOLD;
            end else begin
               wcnt_nx_s = wcnt_r - WCNT_W'(1);
            end
         end
         ST_HOLD: begin
            if ((count_r > CNT_W'(1)) || push_s) begin
               state_nx_s = ST_SETUP;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase

      addr_nx_s  = sram_addr_r;
      wdata_nx_s = sram_wdata_r;
      be_nx_s    = sram_be_r;
      ce_n_nx_s  = 1'b1;
      we_n_nx_s  = 1'b1;
      case (state_nx_s)
         ST_IDLE: begin
            be_nx_s = 4'b1111;
         end
         ST_SETUP: begin
            addr_nx_s  = head_addr_s;
            wdata_nx_s = head_data_s;
            be_nx_s    = head_be_s;
            ce_n_nx_s  = 1'b0;
         end
         ST_WRITE: begin
            ce_n_nx_s = 1'b0;
            we_n_nx_s = 1'b0;
         end
         ST_HOLD: begin
            ce_n_nx_s = 1'b0;
         end
         default: begin
            be_nx_s = 4'b1111;
         end
      endcase
   end

   // Buffer payload write; contents need no reset because count gates them.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         addr_mem_r[wr_ptr_r] <= fmt_addr_s;
         data_mem_r[wr_ptr_r] <= fmt_data_s;
         be_mem_r[wr_ptr_r]   <= fmt_be_s;
      end
   end

   // Buffer pointers and occupancy.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST == `RST_EN) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_next_s;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FSM state, strobe counter, registered SRAM pins and error pulse.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST == `RST_EN) begin
         state_r      <= ST_IDLE;
         wcnt_r       <= WCNT_W'(0);
         sram_addr_r  <= ADDR_W'(0);
         sram_wdata_r <= 32'h0000_0000;
         sram_be_r    <= 4'b1111;
         sram_ce_n_r  <= 1'b1;
         sram_we_n_r  <= 1'b1;
         addr_err_r   <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         wcnt_r       <= wcnt_nx_s;
         sram_addr_r  <= addr_nx_s;
         sram_wdata_r <= wdata_nx_s;
         sram_be_r    <= be_nx_s;
         sram_ce_n_r  <= ce_n_nx_s;
         sram_we_n_r  <= we_n_nx_s;
         addr_err_r   <= accept_s && misalign_s;
      end
   end

endmodule
